// File: rtl/expr_parser.sv
// Line parser for the UART calculator: turns "<num><op><num><CR|LF>" ASCII lines
// into src1/src2/op with a one-cycle done pulse, or a one-cycle error pulse.
module expr_parser (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] src1,
  output logic [15:0] src2,
  output logic [1:0]  op,
  output logic        parser_done,
  output logic        parse_err
);

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 20;

  typedef enum logic [1:0] {S_OP1, S_OP2, S_DONE, S_ERR} state_t;

  state_t         state, state_d;
  logic [W-1:0]   acc1, acc2, acc1_d, acc2_d, acc_sel;
  logic           has1, has2, has1_d, has2_d;
  logic [1:0]     op_r, op_r_d, opc_code;
  logic           load_c, err_c;
  logic           is_digit, is_opc, is_term, is_sp;
  logic [AW-1:0]  prod;
  logic           ovf;

  // Byte classification and the shared acc*10+digit datapath
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_sp    = (rx_data == 8'h20);
    is_opc   = 1'b1;
    opc_code = 2'd0;
    case (rx_data)
      8'h2B:   opc_code = 2'd0;
      8'h2D:   opc_code = 2'd1;
      8'h2A:   opc_code = 2'd2;
      8'h2F:   opc_code = 2'd3;
      default: is_opc   = 1'b0;
    endcase
    acc_sel = (state == S_OP2) ? acc2 : acc1;
    prod    = AW'(acc_sel) * AW'(10) + AW'(rx_data[3:0]);
    ovf     = |prod[AW-1:W];
  end

  // Next-state logic; DONE behaves like OP1 since accumulators are cleared on entry
  always_comb begin
    state_d = (state == S_DONE) ? S_OP1 : state;
    acc1_d  = acc1;
    acc2_d  = acc2;
    has1_d  = has1;
    has2_d  = has2;
    op_r_d  = op_r;
    load_c  = 1'b0;
    err_c   = 1'b0;
    if (rx_valid) begin
      case (state)
        S_OP1, S_DONE: begin
          if (is_digit) begin
            if (ovf) begin
              state_d = S_ERR;
            end else begin
              acc1_d = prod[W-1:0];
              has1_d = 1'b1;
            end
          end else if (is_opc) begin
            if (has1) begin
              op_r_d  = opc_code;
              state_d = S_OP2;
            end else begin
              state_d = S_ERR;
            end
          end else if (is_term) begin
            // A terminator that ends a bad line reports the error immediately
            if (has1) begin
              err_c   = 1'b1;
              state_d = S_OP1;
              acc1_d  = '0;
              acc2_d  = '0;
              has1_d  = 1'b0;
              has2_d  = 1'b0;
            end
          end else if (!is_sp) begin
            state_d = S_ERR;
          end
        end
        S_OP2: begin
          if (is_digit) begin
            if (ovf) begin
              state_d = S_ERR;
            end else begin
              acc2_d = prod[W-1:0];
              has2_d = 1'b1;
            end
          end else if (is_term) begin
            load_c  = has2;
            err_c   = !has2;
            state_d = has2 ? S_DONE : S_OP1;
            acc1_d  = '0;
            acc2_d  = '0;
            has1_d  = 1'b0;
            has2_d  = 1'b0;
          end else if (!is_sp) begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (is_term) begin
            err_c   = 1'b1;
            state_d = S_OP1;
            acc1_d  = '0;
            acc2_d  = '0;
            has1_d  = 1'b0;
            has2_d  = 1'b0;
          end
        end
        default: state_d = S_OP1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_OP1;
      acc1        <= '0;
      acc2        <= '0;
      has1        <= 1'b0;
      has2        <= 1'b0;
      op_r        <= '0;
      src1        <= '0;
      src2        <= '0;
      op          <= '0;
      parser_done <= 1'b0;
      parse_err   <= 1'b0;
    end else begin
      state       <= state_d;
      acc1        <= acc1_d;
      acc2        <= acc2_d;
      has1        <= has1_d;
      has2        <= has2_d;
      op_r        <= op_r_d;
      parser_done <= load_c;
      parse_err   <= err_c;
      if (load_c) begin
        src1 <= acc1;
        src2 <= acc2;
        op   <= op_r;
      end
    end
  end

endmodule
